dual_channel_sampler: RTL and testbench

//  Producer end of the correlator input FIFOs. Counts rising edges on two detector

---
 rtl/dual_channel_sampler_pkg.sv | 15 +
 rtl/dual_channel_sampler_if.sv | 33 +++
 rtl/dual_channel_sampler_edge_counter.sv | 53 +++++
 rtl/dual_channel_sampler.sv | 138 +++++++++++++
 tb/tb_dual_channel_sampler.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_channel_sampler_pkg.sv
// Shared definitions for the dual-channel pulse sampler.
// These are the state encoding and the default count and window widths.
package dual_channel_sampler_pkg;

  localparam int CW_DEFAULT = 8;
  localparam int PW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    COUNT    = 2'd2,
    OVERFLOW = 2'd3
  } state_t;

endpackage

// File: rtl/dual_channel_sampler_if.sv
// Control, detector, FIFO-write and status bundle of the dual-channel sampler.
// master = main control / FIFO side, slave = sampler.
interface dual_channel_sampler_if import dual_channel_sampler_pkg::*; #(
  parameter int CW = CW_DEFAULT,
  parameter int PW = PW_DEFAULT
) ();

  logic          start;
  logic          stop;
  logic          fifo_rst;
  logic [PW-1:0] period;
  logic          pulse_1;
  logic          pulse_2;
  logic          full_1;
  logic          full_2;
  logic [CW-1:0] din_1;
  logic [CW-1:0] din_2;
  logic          wr_1;
  logic          wr_2;
  logic          busy;
  logic          overflow;

  modport master (
    output start, stop, fifo_rst, period, pulse_1, pulse_2, full_1, full_2,
    input  din_1, din_2, wr_1, wr_2, busy, overflow
  );

  modport slave (
    input  start, stop, fifo_rst, period, pulse_1, pulse_2, full_1, full_2,
    output din_1, din_2, wr_1, wr_2, busy, overflow
  );

endinterface

// File: rtl/dual_channel_sampler_edge_counter.sv
// Per-channel rising-edge counter with clear and a count-in-progress sum output.
// With SAMPLER_SATURATE_EN defined the count saturates at all-ones, otherwise it wraps.
module dual_channel_sampler_edge_counter import dual_channel_sampler_pkg::*; #(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse,
  input  logic          clear,
  input  logic          count_en,
  output logic [CW-1:0] sum
);

  logic          pulse_q;
  logic          edge_hit;
  logic [CW-1:0] count;

  // pulse_q tracks the line in every state so a line already high at start is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse;
    end
  end

  assign edge_hit = pulse & ~pulse_q;

`ifdef SAMPLER_SATURATE_EN
  always_comb begin
    sum = count;
    if (edge_hit && (count != {CW{1'b1}})) begin
      sum = count + CW'(1);
    end
  end
`else
  always_comb begin
    sum = count + CW'(edge_hit);
  end
`endif

  // sum includes this cycle's edge, so clearing here still lets the caller capture it
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= sum;
    end
  end

endmodule

// File: rtl/dual_channel_sampler.sv
// Dual-channel pulse sampler that writes aligned per-window edge counts into two FIFOs.
// The optional SAMPLER_SATURATE_EN build makes the per-window counts saturate instead of wrap.
module dual_channel_sampler import dual_channel_sampler_pkg::*; #(
  parameter int CW = CW_DEFAULT,
  parameter int PW = PW_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  dual_channel_sampler_if.slave bus
);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] period_q;
  logic [PW-1:0] win_cnt;
  logic          terminal;
  logic          full_any;
  logic          abort;
  logic          write_go;
  logic          cnt_clear;
  logic          cnt_en;
  logic          busy_c;
  logic          overflow_c;
  logic [CW-1:0] sum_1;
  logic [CW-1:0] sum_2;
  logic [CW-1:0] din_1_q;
  logic [CW-1:0] din_2_q;
  logic          wr_q;

  assign terminal = (win_cnt == '0);
  assign full_any = bus.full_1 | bus.full_2;
  assign abort    = bus.fifo_rst | bus.stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!abort && bus.start) state_next = ARM;
      ARM:      state_next = abort ? IDLE : COUNT;
      COUNT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (terminal && full_any) begin
          state_next = OVERFLOW;
        end
      end
      OVERFLOW: state_next = OVERFLOW;
      default:  state_next = IDLE;
    endcase
  end

  // the terminal cycle both closes the window and restarts the counters, so no dead cycle
  always_comb begin
    busy_c     = 1'b0;
    overflow_c = 1'b0;
    write_go   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ARM: begin
        busy_c    = 1'b1;
        cnt_clear = 1'b1;
      end
      COUNT: begin
        busy_c    = 1'b1;
        cnt_en    = 1'b1;
        cnt_clear = terminal;
        write_go  = terminal && !full_any && !abort;
      end
      OVERFLOW: overflow_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      win_cnt  <= '0;
    end else begin
      if ((state == IDLE) && bus.start && !abort) begin
        period_q <= (bus.period == '0) ? PW'(1) : bus.period;
      end
      if (state == ARM) begin
        win_cnt <= period_q - PW'(1);
      end else if (state == COUNT) begin
        win_cnt <= terminal ? (period_q - PW'(1)) : (win_cnt - PW'(1));
      end
    end
  end

  dual_channel_sampler_edge_counter #(.CW(CW)) u_ch1 (
    .clk      (clk),
    .rst      (rst),
    .pulse    (bus.pulse_1),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .sum      (sum_1)
  );

  dual_channel_sampler_edge_counter #(.CW(CW)) u_ch2 (
    .clk      (clk),
    .rst      (rst),
    .pulse    (bus.pulse_2),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .sum      (sum_2)
  );

  // one shared write strobe keeps both FIFOs in lockstep
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      din_1_q <= '0;
      din_2_q <= '0;
    end else begin
      wr_q <= write_go;
      if (write_go) begin
        din_1_q <= sum_1;
        din_2_q <= sum_2;
      end
    end
  end

  assign bus.din_1    = din_1_q;
  assign bus.din_2    = din_2_q;
  assign bus.wr_1     = wr_q;
  assign bus.wr_2     = wr_q;
  assign bus.busy     = busy_c;
  assign bus.overflow = overflow_c;

endmodule

// File: tb/tb_dual_channel_sampler.sv
// Directed self-checking bench for dual_channel_sampler (CW=4 so the saturation case is reachable).
// Expected din_1 in the 20-edge window depends on whether SAMPLER_SATURATE_EN is defined.
module tb_dual_channel_sampler;

  localparam int CW = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   errors = 0;

  dual_channel_sampler_if #(.CW(CW), .PW(PW)) bus ();

  dual_channel_sampler #(.CW(CW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are observed 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sampling(input logic [PW-1:0] p);
    bus.period = p;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    tick();
  endtask

  task automatic end_sampling();
    bus.stop    = 1'b1;
    bus.pulse_1 = 1'b0;
    bus.pulse_2 = 1'b0;
    tick();
    bus.stop    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.din_1, bus.din_2, bus.wr_1, bus.wr_2, bus.busy, bus.overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got din_1=%0d din_2=%0d wr=%b%b busy=%b ovf=%b, want all 0",
               bus.din_1, bus.din_2, bus.wr_1, bus.wr_2, bus.busy, bus.overflow);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({bus.wr_1, bus.busy, bus.overflow} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got wr=%b busy=%b ovf=%b, want 0 0 0", bus.wr_1, bus.busy, bus.overflow);
    end
  endtask

  // period 6: ch1 pattern 101010 gives 3 edges, ch2 pattern 110000 gives 1 edge
  task automatic test_basic_windows();
    begin_sampling(16'd6);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 6; k++) begin
        bus.pulse_1 = (k % 2 == 0);
        bus.pulse_2 = (k < 2);
        tick();
        tests++;
        if (bus.wr_1 !== bus.wr_2 || bus.wr_1 !== (k == 5) || bus.busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL basic_wr w%0d k%0d: got wr_1=%b wr_2=%b busy=%b, want wr=%b busy=1",
                   w, k, bus.wr_1, bus.wr_2, bus.busy, (k == 5));
        end
        if (k == 5) begin
          tests++;
          if (bus.din_1 !== 4'd3 || bus.din_2 !== 4'd1) begin
            errors++;
            $display("[TB] FAIL basic_din w%0d: got din_1=%0d din_2=%0d, want 3 1", w, bus.din_1, bus.din_2);
          end
        end
      end
    end
    end_sampling();
  endtask

  task automatic test_overflow();
    begin_sampling(16'd2);
    bus.pulse_1 = 1'b1;
    tick();
    bus.full_2 = 1'b1;
    tick();
    bus.full_2 = 1'b0;
    tests++;
    if ({bus.wr_1, bus.wr_2, bus.overflow, bus.busy} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL overflow_entry: got wr=%b%b ovf=%b busy=%b, want wr=00 ovf=1 busy=0",
               bus.wr_1, bus.wr_2, bus.overflow, bus.busy);
    end
    bus.fifo_rst = 1'b1;
    tick();
    bus.fifo_rst = 1'b0;
    tick();
    tests++;
    if (bus.overflow !== 1'b1 || bus.wr_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_fifo_rst: got ovf=%b wr=%b, want ovf=1 wr=0", bus.overflow, bus.wr_1);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    tests++;
    if ({bus.overflow, bus.busy, bus.wr_1, bus.wr_2} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL overflow_start: got ovf=%b busy=%b wr=%b%b, want ovf=1 busy=0 wr=00",
               bus.overflow, bus.busy, bus.wr_1, bus.wr_2);
    end
    bus.pulse_1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (bus.overflow !== 1'b0 || bus.din_1 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL overflow_rst_clear: got ovf=%b din_1=%0d, want 0 0", bus.overflow, bus.din_1);
    end
  endtask

  // period 40 with ch1 toggling: 20 edges into a 4-bit counter
  task automatic test_saturate();
    logic [CW-1:0] want;
`ifdef SAMPLER_SATURATE_EN
    want = 4'd15;
`else
    want = 4'd4;
`endif
    begin_sampling(16'd40);
    for (int k = 0; k < 40; k++) begin
      bus.pulse_1 = (k % 2 == 0);
      tick();
    end
    tests++;
    if (bus.wr_1 !== 1'b1 || bus.din_1 !== want || bus.din_2 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL saturate_din: got wr=%b din_1=%0d din_2=%0d, want wr=1 din_1=%0d din_2=0",
               bus.wr_1, bus.din_1, bus.din_2, want);
    end
    end_sampling();
  endtask

  task automatic test_stop();
    begin_sampling(16'd4);
    bus.pulse_1 = 1'b1;
    tick();
    bus.pulse_1 = 1'b0;
    bus.stop    = 1'b1;
    tick();
    bus.stop    = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.wr_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_abort: got busy=%b wr=%b, want 0 0", bus.busy, bus.wr_1);
    end
    tick();
    tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.wr_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_idle: got busy=%b wr=%b, want 0 0", bus.busy, bus.wr_1);
    end
    begin_sampling(16'd4);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        bus.pulse_1 = (k == 0);
        bus.pulse_2 = (k == 2);
        tick();
        tests++;
        if (bus.wr_1 !== (k == 3) || bus.wr_2 !== (k == 3)) begin
          errors++;
          $display("[TB] FAIL restart_wr w%0d k%0d: got wr=%b%b, want %b", w, k, bus.wr_1, bus.wr_2, (k == 3));
        end
        if (k == 3) begin
          tests++;
          if (bus.din_1 !== 4'd1 || bus.din_2 !== 4'd1) begin
            errors++;
            $display("[TB] FAIL restart_din w%0d: got din_1=%0d din_2=%0d, want 1 1", w, bus.din_1, bus.din_2);
          end
        end
      end
    end
    end_sampling();
  endtask

  task automatic test_fifo_rst();
    begin_sampling(16'd3);
    tick();
    bus.fifo_rst = 1'b1;
    tick();
    bus.fifo_rst = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.wr_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fifo_rst_abort: got busy=%b wr=%b, want 0 0", bus.busy, bus.wr_1);
    end
    bus.pulse_1 = 1'b1;
    tick();
    begin_sampling(16'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    tests++;
    if (bus.wr_1 !== 1'b1 || bus.din_1 !== 4'd0 || bus.din_2 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL held_high_din: got wr=%b din_1=%0d din_2=%0d, want 1 0 0", bus.wr_1, bus.din_1, bus.din_2);
    end
    end_sampling();
  endtask

  // period 0 runs as period 1: a write every cycle carrying that cycle's edge
  task automatic test_back_to_back();
    bus.pulse_1 = 1'b0;
    begin_sampling(16'd0);
    for (int k = 0; k < 8; k++) begin
      bus.pulse_1 = (k % 2 == 0);
      tick();
      tests++;
      if (bus.wr_1 !== 1'b1 || bus.wr_2 !== 1'b1 || bus.din_1 !== CW'(k % 2 == 0) || bus.din_2 !== 4'd0) begin
        errors++;
        $display("[TB] FAIL period0 k%0d: got wr=%b%b din_1=%0d din_2=%0d, want wr=11 din_1=%0d din_2=0",
                 k, bus.wr_1, bus.wr_2, bus.din_1, bus.din_2, (k % 2 == 0));
      end
    end
    end_sampling();
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.fifo_rst = 1'b0;
    bus.period   = '0;
    bus.pulse_1  = 1'b0;
    bus.pulse_2  = 1'b0;
    bus.full_1   = 1'b0;
    bus.full_2   = 1'b0;
    test_reset();
    test_basic_windows();
    test_overflow();
    test_saturate();
    test_stop();
    test_fifo_rst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
